// File: rtl/stamp_logic_mc.sv
// Rate-controlled switching-activity generator: NUM_CHAINS shift chains fed by toggle/LFSR/static sources.
// Optional MISR signature on o_sig is built when STAMP_LOGIC_MC_SIG_EN is defined.
module stamp_logic_mc #(
    parameter int NUM_CHAINS = 4,
    parameter int CHAIN_LEN  = 1024,
    parameter int DUTY_W     = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ena,
    input  logic [NUM_CHAINS-1:0] i_chan_ena,
    input  logic [1:0]            i_mode,
    input  logic [DUTY_W-1:0]     i_duty,
    input  logic [15:0]           i_burst_len,
    input  logic                  i_start,
    input  logic                  i_stop,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [NUM_CHAINS-1:0] o_out,
    output logic                  o_parity,
    output logic [15:0]           o_sig
);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    state_t                  state;
    logic [DUTY_W-1:0]       phase;
    logic [15:0]             count;
    logic                    toggle;
    logic [15:0]             lfsr;
    logic [NUM_CHAINS-1:0]   src;
    logic                    strobe;
    logic                    last_strobe;
    logic                    start_req;

    // x^16+x^14+x^13+x^11+1 Fibonacci step, shared by the LFSR and the MISR
    function automatic logic [15:0] poly_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // A stop request suppresses the strobe in the same cycle it is seen
    assign strobe      = (state == ST_RUN) && i_ena && !i_stop && (phase <= i_duty);
    assign last_strobe = strobe && (count == 16'd1);
    assign start_req   = (state == ST_IDLE) && i_ena && i_start;

    for (genvar k = 0; k < NUM_CHAINS; k++) begin : g_chain
        localparam logic ODD = logic'(k % 2);
        localparam int   TAP = k % 16;

        logic [CHAIN_LEN-1:0] chain;

        assign src[k] = (i_mode == 2'd0) ? (toggle ^ ODD) :
                        (i_mode == 2'd1) ? lfsr[TAP]      :
                                           i_mode[0];

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                chain <= '0;
            end else if (strobe && i_chan_ena[k]) begin
                chain <= {chain[CHAIN_LEN-2:0], src[k]};
            end
        end

        assign o_out[k] = chain[CHAIN_LEN-1];
    end

    // A strobe counter of zero while running means the burst is continuous
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            phase    <= '0;
            count    <= '0;
            toggle   <= 1'b0;
            lfsr     <= LFSR_SEED;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_parity <= 1'b0;
        end else begin
            o_done   <= 1'b0;
            o_parity <= ^o_out;
            if (i_ena) begin
                case (state)
                    ST_IDLE: begin
                        if (i_start) begin
                            state  <= ST_RUN;
                            o_busy <= 1'b1;
                            phase  <= '0;
                            count  <= i_burst_len;
                        end
                    end
                    ST_RUN: begin
                        if (i_stop) begin
                            state  <= ST_IDLE;
                            o_busy <= 1'b0;
                        end else begin
                            phase <= phase + DUTY_W'(1);
                            if (strobe) begin
                                toggle <= ~toggle;
                                lfsr   <= poly_step(lfsr);
                                if (count != 16'd0) begin
                                    count <= count - 16'd1;
                                end
                                if (last_strobe) begin
                                    state  <= ST_IDLE;
                                    o_busy <= 1'b0;
                                    o_done <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef STAMP_LOGIC_MC_SIG_EN
    localparam int FOLD_WORDS = (NUM_CHAINS + 15) / 16;

    logic [FOLD_WORDS*16-1:0] out_pad;
    logic [15:0]              fold_acc [FOLD_WORDS+1];
    logic [15:0]              misr;

    // Chains beyond 16 fold back onto the low signature bits
    assign out_pad     = (FOLD_WORDS*16)'(o_out);
    assign fold_acc[0] = '0;
    for (genvar w = 0; w < FOLD_WORDS; w++) begin : g_fold
        assign fold_acc[w+1] = fold_acc[w] ^ out_pad[w*16 +: 16];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            misr <= '0;
        end else if (start_req) begin
            misr <= '0;
        end else if (strobe) begin
            misr <= poly_step(misr) ^ fold_acc[FOLD_WORDS];
        end
    end

    assign o_sig = misr;
`else
    assign o_sig = 16'h0000;
`endif

endmodule

// File: tb/tb_stamp_logic_mc.sv
// Directed bench for stamp_logic_mc with NUM_CHAINS=2, CHAIN_LEN=8, DUTY_W=4.
// Scenarios run back to back; the mode-0 scenarios share one running strobe count.
module tb_stamp_logic_mc;

    localparam int NC = 2;
    localparam int CL = 8;
    localparam int DW = 4;

    logic          i_clk;
    logic          i_rst;
    logic          i_ena;
    logic [NC-1:0] i_chan_ena;
    logic [1:0]    i_mode;
    logic [DW-1:0] i_duty;
    logic [15:0]   i_burst_len;
    logic          i_start;
    logic          i_stop;
    logic          o_busy;
    logic          o_done;
    logic [NC-1:0] o_out;
    logic          o_parity;
    logic [15:0]   o_sig;

    int total;
    int bad;
    int strobes;

    stamp_logic_mc #(.NUM_CHAINS(NC), .CHAIN_LEN(CL), .DUTY_W(DW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_ena(i_ena), .i_chan_ena(i_chan_ena),
        .i_mode(i_mode), .i_duty(i_duty), .i_burst_len(i_burst_len),
        .i_start(i_start), .i_stop(i_stop), .o_busy(o_busy), .o_done(o_done),
        .o_out(o_out), .o_parity(o_parity), .o_sig(o_sig)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    // Tail pattern of a fully primed mode-0 pair of chains after n strobes since reset
    function automatic logic [1:0] exp_toggle_out(input int n);
        if (n < CL) return 2'b00;
        else if (n % 2 == 0) return 2'b10;
        else return 2'b01;
    endfunction

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic apply_reset;
        i_rst = 1'b1;
        i_start = 1'b0;
        i_stop = 1'b0;
        repeat (3) tick();
        i_rst = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset();
        total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy got=%b want=0", o_busy); end
        total++; if (o_done !== 1'b0) begin bad++; $display("[TB] FAIL rst_done got=%b want=0", o_done); end
        total++; if (o_out !== 2'b00) begin bad++; $display("[TB] FAIL rst_out got=%b want=00", o_out); end
        total++; if (o_parity !== 1'b0) begin bad++; $display("[TB] FAIL rst_parity got=%b want=0", o_parity); end
        total++; if (o_sig !== 16'h0000) begin bad++; $display("[TB] FAIL rst_sig got=%h want=0000", o_sig); end
        // LFSR stream ACE1, 59C3, B387, 670F, CE1E feeds bits [1:0] into chains 0/1
        i_mode = 2'd1; i_duty = 4'd15; i_burst_len = 16'd12; i_chan_ena = 2'b11; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            if (c == 8) begin
                total++; if (o_out !== 2'b00) begin bad++; $display("[TB] FAIL lfsr_n7 got=%b want=00", o_out); end
            end
            if (c == 9) begin
                total++; if (o_out !== 2'b01) begin bad++; $display("[TB] FAIL lfsr_n8 got=%b want=01", o_out); end
            end
            if (c == 10) begin
                total++; if (o_out !== 2'b11) begin bad++; $display("[TB] FAIL lfsr_n9 got=%b want=11", o_out); end
            end
            if (c == 13) begin
                total++; if (o_out !== 2'b10) begin bad++; $display("[TB] FAIL lfsr_n12 got=%b want=10", o_out); end
                total++; if (o_done !== 1'b1) begin bad++; $display("[TB] FAIL lfsr_done got=%b want=1", o_done); end
            end
            tick();
        end
    endtask

    task automatic test_toggle_burst;
        logic [1:0] exp_out;
        logic       exp_prev;
        int         n;
        apply_reset();
        i_mode = 2'd0; i_duty = 4'd15; i_burst_len = 16'd20; i_chan_ena = 2'b11; i_start = 1'b1;
        exp_prev = 1'b0;
        tick();
        i_start = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            n = (c - 1 > 20) ? 20 : c - 1;
            exp_out = exp_toggle_out(n);
            total++; if (o_busy !== (c <= 20)) begin bad++; $display("[TB] FAIL tog_busy c=%0d got=%b want=%b", c, o_busy, (c <= 20)); end
            total++; if (o_done !== (c == 21)) begin bad++; $display("[TB] FAIL tog_done c=%0d got=%b want=%b", c, o_done, (c == 21)); end
            total++; if (o_out !== exp_out) begin bad++; $display("[TB] FAIL tog_out c=%0d got=%b want=%b", c, o_out, exp_out); end
            total++; if (o_parity !== exp_prev) begin bad++; $display("[TB] FAIL tog_parity c=%0d got=%b want=%b", c, o_parity, exp_prev); end
            exp_prev = ^exp_out;
            tick();
        end
        strobes = 20;
    endtask

    task automatic test_throttle;
        logic [1:0] exp_out;
        i_duty = 4'd3; i_burst_len = 16'd8; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            exp_out = exp_toggle_out(strobes);
            total++; if (o_busy !== (c <= 20)) begin bad++; $display("[TB] FAIL thr_busy c=%0d got=%b want=%b", c, o_busy, (c <= 20)); end
            total++; if (o_done !== (c == 21)) begin bad++; $display("[TB] FAIL thr_done c=%0d got=%b want=%b", c, o_done, (c == 21)); end
            total++; if (o_out !== exp_out) begin bad++; $display("[TB] FAIL thr_out c=%0d got=%b want=%b", c, o_out, exp_out); end
            if (c <= 4 || (c >= 17 && c <= 20)) strobes++;
            tick();
        end
    endtask

    task automatic test_pause_abort;
        logic [1:0] exp_out;
        // Five low-enable cycles push completion from cycle 11 to cycle 16
        i_duty = 4'd15; i_burst_len = 16'd10; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            exp_out = exp_toggle_out(strobes);
            total++; if (o_busy !== (c <= 15)) begin bad++; $display("[TB] FAIL pause_busy c=%0d got=%b want=%b", c, o_busy, (c <= 15)); end
            total++; if (o_done !== (c == 16)) begin bad++; $display("[TB] FAIL pause_done c=%0d got=%b want=%b", c, o_done, (c == 16)); end
            total++; if (o_out !== exp_out) begin bad++; $display("[TB] FAIL pause_out c=%0d got=%b want=%b", c, o_out, exp_out); end
            i_ena = !(c >= 3 && c <= 7);
            if (i_ena && c <= 15) strobes++;
            tick();
        end
        i_ena = 1'b1;

        // Start held through the first RUN cycles must not reload the counter
        i_burst_len = 16'd4; i_start = 1'b1;
        tick();
        for (int c = 1; c <= 6; c++) begin
            exp_out = exp_toggle_out(strobes);
            total++; if (o_busy !== (c <= 4)) begin bad++; $display("[TB] FAIL hold_busy c=%0d got=%b want=%b", c, o_busy, (c <= 4)); end
            total++; if (o_done !== (c == 5)) begin bad++; $display("[TB] FAIL hold_done c=%0d got=%b want=%b", c, o_done, (c == 5)); end
            total++; if (o_out !== exp_out) begin bad++; $display("[TB] FAIL hold_out c=%0d got=%b want=%b", c, o_out, exp_out); end
            i_start = (c <= 3);
            if (c <= 4) strobes++;
            tick();
        end

        // Stop alongside start in IDLE is ignored; stop with start in RUN aborts
        i_burst_len = 16'd50; i_start = 1'b1; i_stop = 1'b1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            exp_out = exp_toggle_out(strobes);
            total++; if (o_busy !== (c <= 5)) begin bad++; $display("[TB] FAIL abort_busy c=%0d got=%b want=%b", c, o_busy, (c <= 5)); end
            total++; if (o_done !== 1'b0) begin bad++; $display("[TB] FAIL abort_done c=%0d got=%b want=0", c, o_done); end
            total++; if (o_out !== exp_out) begin bad++; $display("[TB] FAIL abort_out c=%0d got=%b want=%b", c, o_out, exp_out); end
            if (c == 1 || c == 6) begin i_start = 1'b0; i_stop = 1'b0; end
            if (c == 5) begin i_start = 1'b1; i_stop = 1'b1; end
            if (c <= 4) strobes++;
            tick();
        end
    endtask

    task automatic test_continuous_mask;
        logic [1:0] exp_out;
        logic       exp_prev;
        int         n;
        apply_reset();
        i_mode = 2'd0; i_duty = 4'd15; i_burst_len = 16'd0; i_chan_ena = 2'b01; i_start = 1'b1;
        exp_prev = 1'b0;
        tick();
        i_start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            n = c - 1;
            exp_out = {1'b0, (n >= CL + 1) && (n % 2 == 1)};
            total++; if (o_busy !== 1'b1) begin bad++; $display("[TB] FAIL cont_busy c=%0d got=%b want=1", c, o_busy); end
            total++; if (o_done !== 1'b0) begin bad++; $display("[TB] FAIL cont_done c=%0d got=%b want=0", c, o_done); end
            total++; if (o_out !== exp_out) begin bad++; $display("[TB] FAIL cont_out c=%0d got=%b want=%b", c, o_out, exp_out); end
            total++; if (o_parity !== exp_prev) begin bad++; $display("[TB] FAIL cont_parity c=%0d got=%b want=%b", c, o_parity, exp_prev); end
            exp_prev = ^exp_out;
            if (c == 100) i_stop = 1'b1;
            tick();
        end
        i_stop = 1'b0;
        total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL cont_stop_busy got=%b want=0", o_busy); end
        total++; if (o_done !== 1'b0) begin bad++; $display("[TB] FAIL cont_stop_done got=%b want=0", o_done); end
        i_chan_ena = 2'b11;
    endtask

    task automatic test_reset_mid_burst;
        i_mode = 2'd3; i_duty = 4'd15; i_burst_len = 16'd20; i_chan_ena = 2'b11; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (9) tick();
        total++; if (o_out !== 2'b11) begin bad++; $display("[TB] FAIL mid_pre_out got=%b want=11", o_out); end
        total++; if (o_busy !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre_busy got=%b want=1", o_busy); end
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_busy got=%b want=0", o_busy); end
        total++; if (o_done !== 1'b0) begin bad++; $display("[TB] FAIL mid_done got=%b want=0", o_done); end
        total++; if (o_out !== 2'b00) begin bad++; $display("[TB] FAIL mid_out got=%b want=00", o_out); end
        total++; if (o_parity !== 1'b0) begin bad++; $display("[TB] FAIL mid_parity got=%b want=0", o_parity); end
        total++; if (o_sig !== 16'h0000) begin bad++; $display("[TB] FAIL mid_sig got=%h want=0000", o_sig); end
        tick();
        total++; if (o_done !== 1'b0) begin bad++; $display("[TB] FAIL mid_after_done got=%b want=0", o_done); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_after_busy got=%b want=0", o_busy); end
    endtask

    task automatic test_signature;
        logic [15:0] exp_sig;
        logic [15:0] first_sig;
        exp_sig = 16'h0000;
`ifdef STAMP_LOGIC_MC_SIG_EN
        for (int j = 1; j <= 20; j++) begin
            exp_sig = {exp_sig[14:0], exp_sig[15] ^ exp_sig[13] ^ exp_sig[12] ^ exp_sig[10]}
                      ^ {14'd0, exp_toggle_out(j - 1)};
        end
`endif
        first_sig = 16'h0000;
        for (int run = 0; run < 2; run++) begin
            apply_reset();
            i_mode = 2'd0; i_duty = 4'd15; i_burst_len = 16'd20; i_chan_ena = 2'b11; i_start = 1'b1;
            tick();
            i_start = 1'b0;
            for (int i = 0; i < 40 && !o_done; i++) tick();
            total++; if (o_done !== 1'b1) begin bad++; $display("[TB] FAIL sig_done_timeout run=%0d got=%b want=1", run, o_done); end
            repeat (3) tick();
            total++; if (o_sig !== exp_sig) begin bad++; $display("[TB] FAIL sig_value run=%0d got=%h want=%h", run, o_sig, exp_sig); end
`ifdef STAMP_LOGIC_MC_SIG_EN
            if (run == 0) begin
                first_sig = o_sig;
                total++; if (o_sig === 16'h0000) begin bad++; $display("[TB] FAIL sig_nonzero got=%h want=nonzero", o_sig); end
            end else begin
                total++; if (o_sig !== first_sig) begin bad++; $display("[TB] FAIL sig_repeat got=%h want=%h", o_sig, first_sig); end
            end
`endif
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        strobes = 0;
        i_rst = 1'b1;
        i_ena = 1'b1;
        i_chan_ena = 2'b11;
        i_mode = 2'd0;
        i_duty = 4'd15;
        i_burst_len = 16'd0;
        i_start = 1'b0;
        i_stop = 1'b0;
        $display("[TB] starting stamp_logic_mc directed tests");
        test_reset();
        test_toggle_burst();
        test_throttle();
        test_pause_abort();
        test_continuous_mask();
        test_reset_mid_burst();
        test_signature();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
